flash_xip_arbiter: RTL

Two-master arbiter sharing the SoC's single SPI-flash XIP memory port between the CPU (master 0) and a secondary bus master (master 1, e.g. a DMA or boot-copy engine). Sits between the masters' native valid/ready memory interfaces and the flash controller's memory interface. Serialises accesses with round-robin fairness and at most one outstanding transaction. An optional watchdog aborts transactions the flash controller never completes.

---
 rtl/flash_xip_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/flash_xip_arbiter.sv
// flash_xip_arbiter
//   Shares the single SPI-flash XIP memory port between the CPU (master 0)
//   and a secondary bus master (master 1). Round-robin on ties, at most one
//   outstanding transaction, one IDLE cycle between transactions.
//
//   Optional watchdog: build with FLASH_XIP_ARB_TIMEOUT_EN defined to abort a
//   transaction the flash controller never completes (TIMEOUT cycles after
//   s_valid rises). Without it err_timeout is tied to 0 and err_clr is ignored.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   m0_* / m1_*            master request (valid/addr/wdata/wstrb) and
//                          completion (ready/rdata); wstrb==0 means read
//   s_*                    forwarded request to the flash controller and its
//                          completion (s_ready/s_rdata)
//   grant                  one-hot current owner, 2'b00 when idle
//   err_timeout, err_clr   sticky watchdog abort flag and its clear
module flash_xip_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        err_timeout,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t state;
    logic   last_owner;   // 1 after reset so master 0 wins the first tie
    logic   own_valid;
    logic   timeout_hit;

    always_comb begin
        own_valid = 1'b0;
        case (state)
            GNT0:    own_valid = m0_valid;
            GNT1:    own_valid = m1_valid;
            default: own_valid = 1'b0;
        endcase
    end

`ifdef FLASH_XIP_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Abort only while the owner is still requesting; a dropped request or a
    // genuine completion already ends the transaction this cycle.
    assign timeout_hit = own_valid && !s_ready && (wd_cnt == TO_LAST);

    // Entry to a grant state is always from IDLE, so clearing in IDLE is the
    // same as clearing on entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state == IDLE)
                wd_cnt <= '0;
            else if (!s_ready)
                wd_cnt <= wd_cnt + 16'd1;

            if (timeout_hit)
                err_timeout <= 1'b1;
            else if (err_clr)
                err_timeout <= 1'b0;
        end
    end
`else
    logic        unused_err_clr;
    logic [15:0] unused_timeout;

    assign timeout_hit    = 1'b0;
    assign err_timeout    = 1'b0;
    assign unused_err_clr = err_clr;
    assign unused_timeout = TO_LAST;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid && (!m1_valid || last_owner)) begin
                        state      <= GNT0;
                        last_owner <= 1'b0;
                    end else if (m1_valid) begin
                        state      <= GNT1;
                        last_owner <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (!own_valid || s_ready || timeout_hit)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        grant    = {state == GNT1, state == GNT0};
        case (state)
            GNT0: begin
                s_valid  = m0_valid && !timeout_hit;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = m0_valid && (s_ready || timeout_hit);
                if (timeout_hit)
                    m0_rdata = '1;
                else if (m0_valid && s_ready)
                    m0_rdata = s_rdata;
            end
            GNT1: begin
                s_valid  = m1_valid && !timeout_hit;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = m1_valid && (s_ready || timeout_hit);
                if (timeout_hit)
                    m1_rdata = '1;
                else if (m1_valid && s_ready)
                    m1_rdata = s_rdata;
            end
            default: ;
        endcase
    end

endmodule
